// File: rtl/pool_window_sequencer.sv
// 2x2 max-pool window sequencer: walks one plane, issues BRAM reads, aligns valids and output writes.
// Define POOL_EDGE_PAD_EN to emit partial windows for odd width/height instead of dropping them.
module pool_window_sequencer #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DIM_WIDTH       = 10,
  parameter int BRAM_RD_LATENCY = 1,
  parameter int POOL_LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic [ADDR_WIDTH-1:0] rd_addr_3,
  output logic [ADDR_WIDTH-1:0] rd_addr_4,
  output logic                  rd_en_1,
  output logic                  rd_en_2,
  output logic                  rd_en_3,
  output logic                  rd_en_4,
  output logic                  data_valid_1,
  output logic                  data_valid_2,
  output logic                  data_valid_3,
  output logic                  data_valid_4,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done
);

  localparam int L   = BRAM_RD_LATENCY + POOL_LATENCY;
  localparam int IFW = $clog2(L + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [DIM_WIDTH-1:0]  width_q, width_d, height_q, height_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d, row_base_q, row_base_d, out_idx_q, out_idx_d;
  logic [IFW-1:0]        inflight_q, inflight_d;
  logic [3:0]            rd_pipe_q [BRAM_RD_LATENCY];
  logic [L-1:0]          issue_pipe_q;

  logic                  issue, zero_cfg, last_col, last_row, tr_ok, bl_ok;
  logic [DIM_WIDTH:0]    col_x, row_x, width_x, height_x;
  logic [ADDR_WIDTH-1:0] width_a, base_a;

  assign col_x    = {1'b0, col_q};
  assign row_x    = {1'b0, row_q};
  assign width_x  = {1'b0, width_q};
  assign height_x = {1'b0, height_q};
  assign tr_ok    = (col_x + (DIM_WIDTH+1)'(1)) < width_x;
  assign bl_ok    = (row_x + (DIM_WIDTH+1)'(1)) < height_x;

`ifdef POOL_EDGE_PAD_EN
  assign zero_cfg = (cfg_width == '0) || (cfg_height == '0);
  assign last_col = (col_x + (DIM_WIDTH+1)'(2)) >= width_x;
  assign last_row = (row_x + (DIM_WIDTH+1)'(2)) >= height_x;
  assign rd_en_1  = issue;
  assign rd_en_2  = issue & tr_ok;
  assign rd_en_3  = issue & bl_ok;
  assign rd_en_4  = issue & tr_ok & bl_ok;
`else
  // Trailing odd column/row never gets a window, so every issued window is complete.
  assign zero_cfg = (cfg_width < DIM_WIDTH'(2)) || (cfg_height < DIM_WIDTH'(2));
  assign last_col = (col_x + (DIM_WIDTH+1)'(3)) >= width_x;
  assign last_row = (row_x + (DIM_WIDTH+1)'(3)) >= height_x;
  assign rd_en_1  = issue;
  assign rd_en_2  = issue;
  assign rd_en_3  = issue;
  assign rd_en_4  = issue;
`endif

  assign width_a   = ADDR_WIDTH'(width_q);
  assign base_a    = row_base_q + ADDR_WIDTH'(col_q);
  assign rd_addr_1 = base_a;
  assign rd_addr_2 = tr_ok ? base_a + ADDR_WIDTH'(1) : base_a;
  assign rd_addr_3 = bl_ok ? base_a + width_a : base_a;
  assign rd_addr_4 = (tr_ok && bl_ok) ? base_a + width_a + ADDR_WIDTH'(1) : base_a;

  assign {data_valid_1, data_valid_2, data_valid_3, data_valid_4} = rd_pipe_q[BRAM_RD_LATENCY-1];
  assign wr_en   = issue_pipe_q[L-1];
  assign wr_addr = dst_q + out_idx_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    dst_d      = dst_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    out_idx_d  = wr_en ? out_idx_q + ADDR_WIDTH'(1) : out_idx_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          width_d    = cfg_width;
          height_d   = cfg_height;
          dst_d      = cfg_dst_base;
          row_base_d = cfg_src_base;
          row_d      = '0;
          col_d      = '0;
          out_idx_d  = '0;
          state_d    = zero_cfg ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + DIM_WIDTH'(2);
            row_base_d = row_base_q + (width_a << 1);
            if (last_row) state_d = DRAIN;
          end else begin
            col_d = col_q + DIM_WIDTH'(2);
          end
        end
      end
      // Leave as the last write retires so done lands the cycle after it.
      DRAIN:   if (inflight_q == IFW'(wr_en)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = inflight_q + IFW'(issue) - IFW'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      dst_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      row_base_q   <= '0;
      out_idx_q    <= '0;
      inflight_q   <= '0;
      issue_pipe_q <= '0;
      for (int i = 0; i < BRAM_RD_LATENCY; i++) rd_pipe_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      width_q         <= width_d;
      height_q        <= height_d;
      dst_q           <= dst_d;
      row_q           <= row_d;
      col_q           <= col_d;
      row_base_q      <= row_base_d;
      out_idx_q       <= out_idx_d;
      inflight_q      <= inflight_d;
      rd_pipe_q[0]    <= {rd_en_1, rd_en_2, rd_en_3, rd_en_4};
      issue_pipe_q[0] <= issue;
      for (int i = 1; i < BRAM_RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      for (int i = 1; i < L; i++) issue_pipe_q[i] <= issue_pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed self-checking bench for pool_window_sequencer (default parameters).
// Expectations follow POOL_EDGE_PAD_EN when the bench is built with it.
module tb_pool_window_sequencer;

  logic        clk, reset, start, hold;
  logic [9:0]  cfg_width, cfg_height;
  logic [15:0] cfg_src_base, cfg_dst_base;
  logic [15:0] rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4, wr_addr;
  logic        rd_en_1, rd_en_2, rd_en_3, rd_en_4;
  logic        data_valid_1, data_valid_2, data_valid_3, data_valid_4;
  logic        wr_en, busy, done;

  int total = 0;
  int bad   = 0;

  int          winCyc[$];
  logic [15:0] winA1[$], winA4[$];
  logic [3:0]  winEn[$];
  int          wrCyc[$];
  logic [15:0] wrAddr[$];
  int          doneCyc, busyLow, dvFirst, dvCount, holdRd, strays;

  int s1A1[4] = '{32'h100, 32'h102, 32'h108, 32'h10A};
  int s1A4[4] = '{32'h105, 32'h107, 32'h10D, 32'h10F};

`ifdef POOL_EDGE_PAD_EN
  localparam int S2N    = 4;
  localparam int S2Done = 10;
  int s2A1[4] = '{32'h40, 32'h42, 32'h46, 32'h48};
  int s2A4[4] = '{32'h44, 32'h42, 32'h46, 32'h48};
  int s2En[4] = '{32'hF, 32'hA, 32'hC, 32'h8};
`else
  localparam int S2N    = 1;
  localparam int S2Done = 7;
  int s2A1[4] = '{32'h40, 32'h0, 32'h0, 32'h0};
  int s2A4[4] = '{32'h44, 32'h0, 32'h0, 32'h0};
  int s2En[4] = '{32'hF, 32'h0, 32'h0, 32'h0};
`endif

  pool_window_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .hold(hold),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3), .rd_addr_4(rd_addr_4),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_en_3(rd_en_3), .rd_en_4(rd_en_4),
    .data_valid_1(data_valid_1), .data_valid_2(data_valid_2),
    .data_valid_3(data_valid_3), .data_valid_4(data_valid_4),
    .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int w, input int h, input int src, input int dst);
    cfg_width    = 10'(w);
    cfg_height   = 10'(h);
    cfg_src_base = 16'(src);
    cfg_dst_base = 16'(dst);
    start        = 1'b1;
  endtask

  // Steps from the start cycle (cycle 0) and logs every window, write and the done pulse.
  task automatic runCapture(input int maxCyc, input int holdFrom, input int holdLen);
    winCyc.delete(); winA1.delete(); winA4.delete(); winEn.delete();
    wrCyc.delete(); wrAddr.delete();
    doneCyc = -1; busyLow = 0; dvFirst = -1; dvCount = 0; holdRd = 0;
    for (int c = 1; c <= maxCyc && doneCyc < 0; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      hold  = (c >= holdFrom) && (c < holdFrom + holdLen);
      #1;
      if (rd_en_1) begin
        winCyc.push_back(c);
        winA1.push_back(rd_addr_1);
        winA4.push_back(rd_addr_4);
        winEn.push_back({rd_en_1, rd_en_2, rd_en_3, rd_en_4});
      end
      if (hold && (rd_en_1 | rd_en_2 | rd_en_3 | rd_en_4)) holdRd++;
      if (data_valid_1) begin
        if (dvFirst < 0) dvFirst = c;
        dvCount++;
      end
      if (wr_en) begin
        wrCyc.push_back(c);
        wrAddr.push_back(wr_addr);
      end
      if (!busy) busyLow++;
      if (done) doneCyc = c;
    end
    hold = 1'b0;
    checkOutput("done_seen", 32'(doneCyc >= 0), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_src_base = '0; cfg_dst_base = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset_rd_en", {rd_en_1, rd_en_2, rd_en_3, rd_en_4}, 0);
    checkOutput("reset_dv", {data_valid_1, data_valid_2, data_valid_3, data_valid_4}, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_addr", rd_addr_1 | rd_addr_2 | rd_addr_3 | rd_addr_4 | wr_addr, 0);
    reset = 1'b0;
    stepCycle();

    // 4x4 plane, free running
    applyStimulus(4, 4, 32'h100, 32'h200);
    runCapture(40, 0, 0);
    checkOutput("s1_windows", winA1.size(), 4);
    for (int i = 0; i < 4 && i < winA1.size(); i++) begin
      checkOutput("s1_rd_addr_1", winA1[i], s1A1[i]);
      checkOutput("s1_rd_addr_4", winA4[i], s1A4[i]);
      checkOutput("s1_rd_en", winEn[i], 4'hF);
      checkOutput("s1_win_cycle", winCyc[i], i + 1);
    end
    checkOutput("s1_dv_first", dvFirst, 2);
    checkOutput("s1_dv_count", dvCount, 4);
    checkOutput("s1_writes", wrAddr.size(), 4);
    for (int i = 0; i < 4 && i < wrAddr.size(); i++) begin
      checkOutput("s1_wr_addr", wrAddr[i], 32'h200 + i);
      checkOutput("s1_wr_cycle", wrCyc[i], 6 + i);
    end
    checkOutput("s1_done_cycle", doneCyc, 10);
    checkOutput("s1_busy_low", busyLow, 0);
    stepCycle();
    checkOutput("s1_after_busy", busy, 0);
    checkOutput("s1_after_done", done, 0);

    // 3x3 plane: partial windows or dropped edge depending on build
    applyStimulus(3, 3, 32'h40, 32'h80);
    runCapture(40, 0, 0);
    checkOutput("s2_windows", winA1.size(), S2N);
    for (int i = 0; i < S2N && i < winA1.size(); i++) begin
      checkOutput("s2_rd_addr_1", winA1[i], s2A1[i]);
      checkOutput("s2_rd_addr_4", winA4[i], s2A4[i]);
      checkOutput("s2_rd_en", winEn[i], s2En[i]);
    end
    checkOutput("s2_writes", wrAddr.size(), S2N);
    for (int i = 0; i < S2N && i < wrAddr.size(); i++)
      checkOutput("s2_wr_addr", wrAddr[i], 32'h80 + i);
    checkOutput("s2_done_cycle", doneCyc, S2Done);
    stepCycle();

    // 4x2 plane with hold in cycles 2..4
    applyStimulus(4, 2, 32'h300, 32'h400);
    runCapture(40, 2, 3);
    checkOutput("s3_windows", winA1.size(), 2);
    for (int i = 0; i < 2 && i < winA1.size(); i++) begin
      checkOutput("s3_rd_addr_1", winA1[i], 32'h300 + 2 * i);
      checkOutput("s3_win_cycle", winCyc[i], 1 + 4 * i);
    end
    checkOutput("s3_hold_rd", holdRd, 0);
    checkOutput("s3_writes", wrAddr.size(), 2);
    for (int i = 0; i < 2 && i < wrAddr.size(); i++) begin
      checkOutput("s3_wr_addr", wrAddr[i], 32'h400 + i);
      checkOutput("s3_wr_cycle", wrCyc[i], 6 + 4 * i);
    end
    checkOutput("s3_done_cycle", doneCyc, 11);
    stepCycle();

    // Reset two cycles into an 8x8 run, then a clean restart
    applyStimulus(8, 8, 32'h500, 32'h600);
    stepCycle();
    start = 1'b0;
    checkOutput("s4_running", rd_en_1, 1);
    stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("s4_rst_rd_en", {rd_en_1, rd_en_2, rd_en_3, rd_en_4}, 0);
    checkOutput("s4_rst_dv", {data_valid_1, data_valid_2, data_valid_3, data_valid_4}, 0);
    checkOutput("s4_rst_wr_en", wr_en, 0);
    checkOutput("s4_rst_busy", busy, 0);
    checkOutput("s4_rst_done", done, 0);
    checkOutput("s4_rst_addr", rd_addr_1 | rd_addr_2 | rd_addr_3 | rd_addr_4 | wr_addr, 0);
    reset = 1'b0;
    strays = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (wr_en || done || busy || data_valid_1) strays++;
    end
    checkOutput("s4_no_leftover", strays, 0);
    applyStimulus(4, 4, 32'h100, 32'h200);
    runCapture(40, 0, 0);
    checkOutput("s4_windows", winA1.size(), 4);
    checkOutput("s4_writes", wrAddr.size(), 4);
    checkOutput("s4_done_cycle", doneCyc, 10);
    stepCycle();

    // Zero width, plus a second start while busy
    applyStimulus(0, 5, 32'h10, 32'h20);
    stepCycle();
    applyStimulus(4, 4, 32'h100, 32'h200);
    #1;
    checkOutput("s5_busy", busy, 1);
    checkOutput("s5_done", done, 1);
    checkOutput("s5_rd_en", {rd_en_1, rd_en_2, rd_en_3, rd_en_4}, 0);
    stepCycle();
    start = 1'b0;
    #1;
    checkOutput("s5_idle_busy", busy, 0);
    checkOutput("s5_idle_done", done, 0);
    strays = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (rd_en_1 || wr_en || busy || done) strays++;
    end
    checkOutput("s5_start_ignored", strays, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
